pc_gen: RTL and testbench

//   Fetch-stage program counter unit. It replaces the bare PC+4 incrementer with a registered PC
//   and a parametrised step. It handles stall hold, branch/jump redirect, exception entry and eret

---
 rtl/pc_gen.sv | 65 ++++++
 tb/tb_pc_gen.sv | 133 +++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program counter with stall hold, a one-entry redirect buffer,
// exception entry and eret return.
module pc_gen #(
    parameter int               WIDTH    = 32,
    parameter int               STEP     = 4,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h3000),
    parameter logic [WIDTH-1:0] EXC_VEC  = WIDTH'(32'h4180),
    parameter logic [WIDTH-1:0] IMEM_LO  = WIDTH'(32'h3000),
    parameter logic [WIDTH-1:0] IMEM_HI  = WIDTH'(32'h6ffc)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_target,
    input  logic             exc_req,
    input  logic             eret_req,
    input  logic [WIDTH-1:0] epc,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_step,
    output logic             pending,
    output logic             fetch_adel
);
    typedef enum logic {RUN, HOLD} state_t;
    state_t           state, state_nxt;
    logic [WIDTH-1:0] pc_nxt, tgt, tgt_nxt;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            pc    <= RESET_PC;
            tgt   <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            tgt   <= tgt_nxt;
        end
    end
    // a redirect arriving together with a buffered one on stall release is dropped
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_step;
        tgt_nxt   = tgt;
        if (exc_req) begin
            pc_nxt    = EXC_VEC;
            state_nxt = RUN;
        end else if (eret_req) begin
            pc_nxt    = epc;
            state_nxt = RUN;
        end else if (stall) begin
            pc_nxt = pc;
            if (redirect_valid) begin
                tgt_nxt   = redirect_target;
                state_nxt = HOLD;
            end
        end else if (state == HOLD) begin
            pc_nxt    = tgt;
            state_nxt = RUN;
        end else if (redirect_valid) begin
            pc_nxt = redirect_target;
        end
    end
    assign pc_step    = pc + WIDTH'(STEP);
    assign pending    = state == HOLD;
    assign fetch_adel = (pc[1:0] != 2'b00) || (pc < IMEM_LO) || (pc > IMEM_HI);
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed vector table followed by randomized traffic against a queue-based model.
module tb_pc_gen;
    localparam bit H = 1'b1, L = 1'b0;
    logic        clk = 1'b0;
    logic        reset, stall, redirect_valid, exc_req, eret_req;
    logic [31:0] redirect_target, epc, pc, pc_step;
    logic        pending, fetch_adel;
    int          n_cmp = 0, n_bad = 0;

    pc_gen dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .exc_req(exc_req), .eret_req(eret_req),
        .epc(epc), .pc(pc), .pc_step(pc_step), .pending(pending), .fetch_adel(fetch_adel)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst, stl, rv;
        logic [31:0] rt;
        bit          exc, ert;
        logic [31:0] epc;
        logic [31:0] xpc;
        bit          xpend, xadel;
    } vec_t;

    // reference model: a queue of at most one buffered redirect
    logic [31:0] m_pc;
    logic [31:0] m_buf[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit adel_of(input logic [31:0] p);
        return (p % 4 != 0) || (p < 32'h3000) || (p > 32'h6ffc);
    endfunction

    task automatic step(input bit r, input bit s, input bit rv, input logic [31:0] rt,
                        input bit e, input bit er, input logic [31:0] ep);
        reset = r; stall = s; redirect_valid = rv; redirect_target = rt;
        exc_req = e; eret_req = er; epc = ep;
        @(posedge clk);
        #1;
        if (r) begin
            m_pc = 32'h3000; m_buf.delete();
        end else if (e) begin
            m_pc = 32'h4180; m_buf.delete();
        end else if (er) begin
            m_pc = ep; m_buf.delete();
        end else if (s) begin
            if (rv) begin m_buf.delete(); m_buf.push_back(rt); end
        end else if (m_buf.size() != 0) begin
            m_pc = m_buf.pop_front();
        end else if (rv) begin
            m_pc = rt;
        end else begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    vec_t vt[28];

    initial begin
        reset = H; stall = L; redirect_valid = L; redirect_target = '0;
        exc_req = L; eret_req = L; epc = '0;
        m_pc = 32'h3000;
        //        rst stl rv  target        exc ert epc           exp pc        pend adel
        vt[0]  = '{H, L, L, 32'h0,         L, L, 32'h0,         32'h3000,     L, L};
        vt[1]  = '{H, L, L, 32'h0,         L, L, 32'h0,         32'h3000,     L, L};
        vt[2]  = '{L, L, L, 32'h0,         L, L, 32'h0,         32'h3004,     L, L};
        vt[3]  = '{L, L, L, 32'h0,         L, L, 32'h0,         32'h3008,     L, L};
        vt[4]  = '{L, L, H, 32'h3100,      L, L, 32'h0,         32'h3100,     L, L};
        vt[5]  = '{L, L, L, 32'h0,         L, L, 32'h0,         32'h3104,     L, L};
        vt[6]  = '{L, H, H, 32'h3200,      L, L, 32'h0,         32'h3104,     H, L};
        vt[7]  = '{L, H, H, 32'h3300,      L, L, 32'h0,         32'h3104,     H, L};
        vt[8]  = '{L, H, L, 32'h0,         L, L, 32'h0,         32'h3104,     H, L};
        vt[9]  = '{L, L, L, 32'h0,         L, L, 32'h0,         32'h3300,     L, L};
        vt[10] = '{L, L, L, 32'h0,         L, L, 32'h0,         32'h3304,     L, L};
        vt[11] = '{L, H, H, 32'h3400,      L, L, 32'h0,         32'h3304,     H, L};
        vt[12] = '{L, H, L, 32'h0,         H, L, 32'h0,         32'h4180,     L, L};
        vt[13] = '{L, H, H, 32'h3500,      L, L, 32'h0,         32'h4180,     H, L};
        vt[14] = '{H, H, L, 32'h0,         L, L, 32'h0,         32'h3000,     L, L};
        vt[15] = '{L, L, L, 32'h0,         L, H, 32'h300c,      32'h300c,     L, L};
        vt[16] = '{L, L, L, 32'h0,         L, H, 32'h3002,      32'h3002,     L, H};
        vt[17] = '{L, L, H, 32'hfffffffc,  L, L, 32'h0,         32'hfffffffc, L, H};
        vt[18] = '{L, L, L, 32'h0,         L, L, 32'h0,         32'h0,        L, H};
        vt[19] = '{L, L, L, 32'h0,         H, L, 32'h0,         32'h4180,     L, L};
        vt[20] = '{L, H, L, 32'h0,         L, L, 32'h0,         32'h4180,     L, L};
        vt[21] = '{L, H, H, 32'h3600,      L, L, 32'h0,         32'h4180,     H, L};
        vt[22] = '{L, L, H, 32'h3700,      L, L, 32'h0,         32'h3600,     L, L};
        vt[23] = '{L, L, L, 32'h0,         L, L, 32'h0,         32'h3604,     L, L};
        vt[24] = '{L, H, H, 32'h1234,      L, H, 32'h5000,      32'h5000,     L, L};
        vt[25] = '{L, L, H, 32'h6ffc,      L, L, 32'h0,         32'h6ffc,     L, L};
        vt[26] = '{L, L, L, 32'h0,         L, L, 32'h0,         32'h7000,     L, H};
        vt[27] = '{L, L, H, 32'h2ffc,      L, L, 32'h0,         32'h2ffc,     L, H};

        for (int i = 0; i < 28; i++) begin
            step(vt[i].rst, vt[i].stl, vt[i].rv, vt[i].rt, vt[i].exc, vt[i].ert, vt[i].epc);
            check($sformatf("vec%0d pc", i), pc, vt[i].xpc);
            check($sformatf("vec%0d pc_step", i), pc_step, vt[i].xpc + 32'd4);
            check($sformatf("vec%0d pending", i), {31'b0, pending}, {31'b0, vt[i].xpend});
            check($sformatf("vec%0d fetch_adel", i), {31'b0, fetch_adel}, {31'b0, vt[i].xadel});
        end

        step(H, L, L, '0, L, L, '0);
        for (int i = 0; i < 3000; i++) begin
            bit          r, s, rv, e, er;
            logic [31:0] rt, ep;
            r  = ($urandom_range(0, 63) == 0);
            e  = ($urandom_range(0, 19) == 0);
            er = ($urandom_range(0, 19) == 0);
            s  = ($urandom_range(0, 2) == 0);
            rv = ($urandom_range(0, 2) == 0);
            rt = 32'h3000 + ($urandom_range(0, 32'h3fff) & 32'hfffc);
            ep = 32'h3000 + $urandom_range(0, 32'h3fff);
            if ($urandom_range(0, 15) == 0) rt = rt | 32'h1;
            if ($urandom_range(0, 31) == 0) rt = 32'hfffffff8;
            step(r, s, rv, rt, e, er, ep);
            check("rand pc", pc, m_pc);
            check("rand pc_step", pc_step, m_pc + 32'd4);
            check("rand pending", {31'b0, pending}, {31'b0, m_buf.size() != 0});
            check("rand fetch_adel", {31'b0, fetch_adel}, {31'b0, adel_of(m_pc)});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
